// File: rtl/aidc_lite_comp_arb.sv
// aidc_lite_comp_arb: collects done/fail/length from NUM_COMP compressor
// engines, selects a winner (auto-smallest, forced, or raw bypass) with a
// WAIT timeout, then streams the winning buffer over a valid/ready port.
module aidc_lite_comp_arb #(
  parameter  int NUM_COMP = 3,
  parameter  int DATA_W   = 64,
  parameter  int ADDR_W   = 3,
  parameter  int TIMEOUT  = 255,
  localparam int LEN_W    = ADDR_W + 1,
  localparam int SEL_W    = $clog2(NUM_COMP + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [1:0]                 mode_i,
  input  logic [SEL_W-1:0]           force_sel_i,
  input  logic [LEN_W-1:0]           raw_len_i,
  input  logic [NUM_COMP-1:0]        done_i,
  input  logic [NUM_COMP-1:0]        fail_i,
  input  logic [NUM_COMP*LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0]          buf_raddr_o,
  input  logic [NUM_COMP*DATA_W-1:0] rdata_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       out_last_o,
  output logic [SEL_W-1:0]           sel_o,
  output logic [LEN_W-1:0]           sel_len_o,
  output logic                       timeout_o,
  output logic                       done_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    PICK  = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    OUT   = 3'd5,
    FIN   = 3'd6
  } state_t;

  state_t                         state;
  state_t                         state_next;

  logic [1:0]                     mode;
  logic [SEL_W-1:0]               force_sel;
  logic [LEN_W-1:0]               raw_len;
  logic [NUM_COMP-1:0]            done_q;
  logic [NUM_COMP-1:0]            fail_q;
  logic [NUM_COMP-1:0][LEN_W-1:0] len_q;
  logic [15:0]                    timer;

  logic                           all_done;
  logic                           expire;
  logic                           is_last;
  logic [NUM_COMP-1:0]            cand;
  logic                           found;
  logic                           take;
  logic [SEL_W-1:0]               best;
  logic [LEN_W-1:0]               best_len;
  logic [SEL_W-1:0]               pick_sel;
  logic [LEN_W-1:0]               pick_len;
  logic [DATA_W-1:0]              sel_data;

  // Engines count as done if already latched or reporting done this cycle.
  assign all_done = &(done_q | done_i);
  assign expire   = (timer == 16'(TIMEOUT - 1));
  assign is_last  = ({1'b0, buf_raddr_o} == (sel_len_o - LEN_W'(1)));

  // Winner selection: strict less-than keeps the lowest index on equal length.
  always_comb begin
    cand     = {NUM_COMP{1'b0}};
    found    = 1'b0;
    take     = 1'b0;
    best     = {SEL_W{1'b0}};
    best_len = {LEN_W{1'b0}};
    for (int k = 0; k < NUM_COMP; k++) begin
      cand[k] = done_q[k] & ~fail_q[k] & (len_q[k] != {LEN_W{1'b0}}) & (len_q[k] < raw_len);
      case (mode)
        2'd0:    take = cand[k] & (~found | (len_q[k] < best_len));
        2'd1:    take = cand[k] & (force_sel == SEL_W'(k));
        default: take = 1'b0;
      endcase
      best     = take ? SEL_W'(k) : best;
      best_len = take ? len_q[k] : best_len;
      found    = found | take;
    end
    pick_sel = found ? best : SEL_W'(NUM_COMP);
    pick_len = found ? best_len : raw_len;
  end

  // Read-data mux for the selected engine's buffer.
  always_comb begin
    sel_data = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_COMP; k++) begin
      sel_data = (sel_o == SEL_W'(k)) ? rdata_i[k*DATA_W +: DATA_W] : sel_data;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start_i ? WAIT : IDLE;
      WAIT:    state_next = (all_done || expire) ? PICK : WAIT;
      PICK:    state_next = found ? RADDR : FIN;
      RADDR:   state_next = RDATA;
      RDATA:   state_next = OUT;
      OUT: begin
        if (out_ready_i) begin
          state_next = is_last ? FIN : RADDR;
        end else begin
          state_next = OUT;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Block context, engine result latches, timer, and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= 2'd0;
      force_sel   <= {SEL_W{1'b0}};
      raw_len     <= {LEN_W{1'b0}};
      done_q      <= {NUM_COMP{1'b0}};
      fail_q      <= {NUM_COMP{1'b0}};
      len_q       <= {(NUM_COMP*LEN_W){1'b0}};
      timer       <= 16'd0;
      buf_raddr_o <= {ADDR_W{1'b0}};
      out_valid_o <= 1'b0;
      out_data_o  <= {DATA_W{1'b0}};
      out_last_o  <= 1'b0;
      sel_o       <= {SEL_W{1'b0}};
      sel_len_o   <= {LEN_W{1'b0}};
      timeout_o   <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= (state == FIN);
      case (state)
        IDLE: begin
          if (start_i) begin
            mode      <= mode_i;
            force_sel <= force_sel_i;
            raw_len   <= raw_len_i;
            done_q    <= {NUM_COMP{1'b0}};
            fail_q    <= {NUM_COMP{1'b0}};
            len_q     <= {(NUM_COMP*LEN_W){1'b0}};
            timer     <= 16'd0;
            timeout_o <= 1'b0;
          end
        end
        WAIT: begin
          for (int k = 0; k < NUM_COMP; k++) begin
            if (done_i[k] && !done_q[k]) begin
              done_q[k] <= 1'b1;
              fail_q[k] <= fail_i[k];
              len_q[k]  <= len_i[k*LEN_W +: LEN_W];
            end
          end
          if (timer != 16'hFFFF) begin
            timer <= timer + 16'd1;
          end
          if (expire && !all_done) begin
            timeout_o <= 1'b1;
          end
        end
        PICK: begin
          sel_o       <= pick_sel;
          sel_len_o   <= pick_len;
          buf_raddr_o <= {ADDR_W{1'b0}};
        end
        RDATA: begin
          out_data_o  <= sel_data;
          out_valid_o <= 1'b1;
          out_last_o  <= is_last;
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            if (!is_last) begin
              buf_raddr_o <= buf_raddr_o + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aidc_lite_comp_arb.sv
// Directed testbench for aidc_lite_comp_arb (NUM_COMP=3, DATA_W=64,
// ADDR_W=3, TIMEOUT=20). Engine buffers are modelled as synchronous-read
// memories whose word content encodes engine index and address.
module tb_aidc_lite_comp_arb;
  localparam int NC = 3;
  localparam int DW = 64;
  localparam int AW = 3;
  localparam int LW = 4;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [1:0]       mode_i = 2'd0;
  logic [SW-1:0]    force_sel_i = '0;
  logic [LW-1:0]    raw_len_i = '0;
  logic [NC-1:0]    done_i = '0;
  logic [NC-1:0]    fail_i = '0;
  logic [NC*LW-1:0] len_i = '0;
  logic [AW-1:0]    buf_raddr_o;
  logic [NC*DW-1:0] rdata_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [DW-1:0]    out_data_o;
  logic             out_last_o;
  logic [SW-1:0]    sel_o;
  logic [LW-1:0]    sel_len_o;
  logic             timeout_o;
  logic             done_o;

  int vectors = 0;
  int errors  = 0;
  logic [63:0] got_data [16];
  logic        got_last [16];

  aidc_lite_comp_arb #(.NUM_COMP(NC), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .force_sel_i(force_sel_i), .raw_len_i(raw_len_i), .done_i(done_i),
    .fail_i(fail_i), .len_i(len_i), .buf_raddr_o(buf_raddr_o),
    .rdata_i(rdata_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .sel_o(sel_o),
    .sel_len_o(sel_len_o), .timeout_o(timeout_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int k, input int a);
    return 64'hA5C3_0000_0000_0000 ^ (64'(k + 1) << 32) ^ (64'(a) * 64'h0000_0000_0001_0001);
  endfunction

  // Buffer model: one-cycle read latency from the shared address.
  always @(posedge clk) begin
    for (int k = 0; k < NC; k++) rdata_i[k*DW +: DW] <= pat(k, int'(buf_raddr_o));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [1:0] m, input logic [SW-1:0] fs, input logic [LW-1:0] rl);
    start_i = 1'b1; mode_i = m; force_sel_i = fs; raw_len_i = rl;
    step();
    start_i = 1'b0;
  endtask

  task automatic apply_done(input logic [2:0] m, input logic [2:0] f,
                            input logic [3:0] l0, input logic [3:0] l1, input logic [3:0] l2);
    done_i = m; fail_i = f; len_i = {l2, l1, l0};
    step();
    done_i = '0; fail_i = '0; len_i = '0;
  endtask

  // Called in PICK; counts cycles after PICK, records accepted words,
  // optionally stalls one word, returns when done_o is seen (or -1).
  task automatic collect(input int stall_word, input int stall_cycles,
                         output int nwords, output int done_cyc, output int unstable);
    int stalled;
    logic [63:0] hd;
    logic hl;
    logic [AW-1:0] ha;
    nwords = 0; done_cyc = -1; unstable = 0; stalled = 0;
    hd = '0; hl = 1'b0; ha = '0;
    out_ready_i = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (done_o) begin
        done_cyc = c;
        break;
      end
      if (out_valid_o) begin
        if (stalled > 0 && {out_data_o, out_last_o, buf_raddr_o} !== {hd, hl, ha}) unstable++;
        if (nwords == stall_word && stalled < stall_cycles) begin
          if (stalled == 0) begin
            hd = out_data_o; hl = out_last_o; ha = buf_raddr_o;
          end
          stalled++;
          out_ready_i = 1'b0;
        end else begin
          if (nwords < 16) begin
            got_data[nwords] = out_data_o;
            got_last[nwords] = out_last_o;
          end
          nwords++;
          stalled = (stalled > 0) ? -1000 : stalled;
          out_ready_i = 1'b1;
        end
      end else begin
        out_ready_i = 1'b0;
      end
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    vectors++;
    if ({buf_raddr_o, out_valid_o, out_last_o, sel_o, sel_len_o, timeout_o, done_o} !== 14'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected all zero",
               {buf_raddr_o, out_valid_o, out_last_o, sel_o, sel_len_o, timeout_o, done_o});
    end
    vectors++;
    if (out_data_o !== 64'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", out_data_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_auto();
    int n, dc, un;
    start_block(2'd0, 2'd0, 4'd8);
    apply_done(3'b111, 3'b000, 4'd5, 4'd3, 4'd3);
    collect(-1, 0, n, dc, un);
    vectors++;
    if ({sel_o, sel_len_o} !== {2'd1, 4'd3}) begin
      errors++; $display("FAIL auto_sel: got sel %0d len %0d expected sel 1 len 3", sel_o, sel_len_o);
    end
    vectors++;
    if (n != 3 || dc != 11) begin
      errors++; $display("FAIL auto_count: got %0d words done@%0d expected 3 words done@11", n, dc);
    end
    for (int i = 0; i < n && i < 16; i++) begin
      vectors++;
      if (got_data[i] !== pat(1, i) || got_last[i] !== (i == n - 1)) begin
        errors++;
        $display("FAIL auto_word%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], pat(1, i), i == n - 1);
      end
    end
    vectors++;
    if (timeout_o !== 1'b0) begin
      errors++; $display("FAIL auto_timeout: got %b expected 0", timeout_o);
    end
  endtask

  task automatic test_raw();
    int n, dc, un;
    start_block(2'd0, 2'd0, 4'd8);
    apply_done(3'b111, 3'b000, 4'd8, 4'd9, 4'd8);
    collect(-1, 0, n, dc, un);
    vectors++;
    if ({sel_o, sel_len_o} !== {2'd3, 4'd8} || n != 0 || dc != 2) begin
      errors++;
      $display("FAIL raw_len: got sel %0d len %0d words %0d done@%0d expected sel 3 len 8 words 0 done@2",
               sel_o, sel_len_o, n, dc);
    end
    start_block(2'd0, 2'd0, 4'd8);
    apply_done(3'b111, 3'b111, 4'd2, 4'd2, 4'd2);
    collect(-1, 0, n, dc, un);
    vectors++;
    if (sel_o !== 2'd3 || n != 0 || dc != 2) begin
      errors++; $display("FAIL raw_fail: got sel %0d words %0d done@%0d expected sel 3 words 0 done@2", sel_o, n, dc);
    end
    start_block(2'd0, 2'd0, 4'd8);
    apply_done(3'b111, 3'b000, 4'd0, 4'd7, 4'd0);
    collect(-1, 0, n, dc, un);
    vectors++;
    if ({sel_o, sel_len_o} !== {2'd1, 4'd7} || n != 7) begin
      errors++; $display("FAIL zero_len: got sel %0d len %0d words %0d expected sel 1 len 7 words 7", sel_o, sel_len_o, n);
    end
  endtask

  task automatic test_forced();
    int n, dc, un;
    start_block(2'd1, 2'd2, 4'd8);
    apply_done(3'b111, 3'b000, 4'd2, 4'd7, 4'd6);
    collect(-1, 0, n, dc, un);
    vectors++;
    if ({sel_o, sel_len_o} !== {2'd2, 4'd6} || n != 6 || dc != 20) begin
      errors++;
      $display("FAIL forced_sel: got sel %0d len %0d words %0d done@%0d expected sel 2 len 6 words 6 done@20",
               sel_o, sel_len_o, n, dc);
    end
    for (int i = 0; i < n && i < 16; i++) begin
      vectors++;
      if (got_data[i] !== pat(2, i) || got_last[i] !== (i == n - 1)) begin
        errors++;
        $display("FAIL forced_word%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], pat(2, i), i == n - 1);
      end
    end
    start_block(2'd1, 2'd2, 4'd8);
    apply_done(3'b111, 3'b100, 4'd2, 4'd7, 4'd6);
    collect(-1, 0, n, dc, un);
    vectors++;
    if ({sel_o, sel_len_o} !== {2'd3, 4'd8} || n != 0) begin
      errors++; $display("FAIL forced_fail: got sel %0d len %0d words %0d expected sel 3 len 8 words 0", sel_o, sel_len_o, n);
    end
    start_block(2'd1, 2'd3, 4'd8);
    apply_done(3'b111, 3'b000, 4'd2, 4'd7, 4'd6);
    collect(-1, 0, n, dc, un);
    vectors++;
    if (sel_o !== 2'd3 || n != 0) begin
      errors++; $display("FAIL forced_range: got sel %0d words %0d expected sel 3 words 0", sel_o, n);
    end
  endtask

  task automatic test_timeout();
    int n, dc, un;
    start_block(2'd0, 2'd0, 4'd8);
    apply_done(3'b011, 3'b000, 4'd4, 4'd2, 4'd0);
    repeat (18) step();
    vectors++;
    if (timeout_o !== 1'b0) begin
      errors++; $display("FAIL timeout_early: got %b expected 0", timeout_o);
    end
    step();
    vectors++;
    if (timeout_o !== 1'b1) begin
      errors++; $display("FAIL timeout_set: got %b expected 1", timeout_o);
    end
    collect(-1, 0, n, dc, un);
    vectors++;
    if ({sel_o, sel_len_o, timeout_o} !== {2'd1, 4'd2, 1'b1} || n != 2 || dc != 8) begin
      errors++;
      $display("FAIL timeout_sel: got sel %0d len %0d to %b words %0d done@%0d expected sel 1 len 2 to 1 words 2 done@8",
               sel_o, sel_len_o, timeout_o, n, dc);
    end
    for (int i = 0; i < n && i < 16; i++) begin
      vectors++;
      if (got_data[i] !== pat(1, i) || got_last[i] !== (i == n - 1)) begin
        errors++;
        $display("FAIL timeout_word%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], pat(1, i), i == n - 1);
      end
    end
    start_block(2'd0, 2'd0, 4'd8);
    vectors++;
    if (timeout_o !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got %b expected 0", timeout_o);
    end
    repeat (19) step();
    apply_done(3'b111, 3'b000, 4'd5, 4'd6, 4'd4);
    vectors++;
    if (timeout_o !== 1'b0) begin
      errors++; $display("FAIL timeout_tie: got %b expected 0", timeout_o);
    end
    collect(-1, 0, n, dc, un);
    vectors++;
    if ({sel_o, sel_len_o} !== {2'd2, 4'd4} || n != 4) begin
      errors++; $display("FAIL timeout_tie_sel: got sel %0d len %0d words %0d expected sel 2 len 4 words 4", sel_o, sel_len_o, n);
    end
  endtask

  task automatic test_backpressure();
    int n, dc, un;
    start_block(2'd0, 2'd0, 4'd8);
    apply_done(3'b111, 3'b000, 4'd4, 4'd6, 4'd7);
    collect(1, 5, n, dc, un);
    vectors++;
    if ({sel_o, sel_len_o} !== {2'd0, 4'd4} || n != 4 || dc != 19 || un != 0) begin
      errors++;
      $display("FAIL bp_stream: got sel %0d len %0d words %0d done@%0d unstable %0d expected sel 0 len 4 words 4 done@19 unstable 0",
               sel_o, sel_len_o, n, dc, un);
    end
    for (int i = 0; i < n && i < 16; i++) begin
      vectors++;
      if (got_data[i] !== pat(0, i) || got_last[i] !== (i == n - 1)) begin
        errors++;
        $display("FAIL bp_word%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], pat(0, i), i == n - 1);
      end
    end
  endtask

  task automatic test_robustness();
    int n, dc, un, dones;
    start_block(2'd0, 2'd0, 4'd8);
    apply_done(3'b111, 3'b000, 4'd5, 4'd3, 4'd3);
    out_ready_i = 1'b1;
    repeat (3) step();
    vectors++;
    if (out_valid_o !== 1'b1 || out_data_o !== pat(1, 0)) begin
      errors++; $display("FAIL mid_word0: got %b/%h expected 1/%h", out_valid_o, out_data_o, pat(1, 0));
    end
    step(); step();
    rst = 1'b1;
    step();
    vectors++;
    if ({buf_raddr_o, out_valid_o, out_last_o, sel_o, sel_len_o, timeout_o, done_o} !== 14'd0 || out_data_o !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b/%h expected all zero",
               {buf_raddr_o, out_valid_o, out_last_o, sel_o, sel_len_o, timeout_o, done_o}, out_data_o);
    end
    rst = 1'b0; out_ready_i = 1'b0;
    dones = 0;
    repeat (6) begin
      step();
      if (done_o) dones++;
    end
    vectors++;
    if (dones != 0) begin
      errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", dones);
    end
    start_block(2'd0, 2'd0, 4'd8);
    start_block(2'd2, 2'd0, 4'd4);
    apply_done(3'b111, 3'b000, 4'd5, 4'd3, 4'd3);
    collect(-1, 0, n, dc, un);
    vectors++;
    if ({sel_o, sel_len_o} !== {2'd1, 4'd3} || n != 3 || dc != 11) begin
      errors++;
      $display("FAIL wait_restart: got sel %0d len %0d words %0d done@%0d expected sel 1 len 3 words 3 done@11",
               sel_o, sel_len_o, n, dc);
    end
    done_i = 3'b111; len_i = {4'd1, 4'd1, 4'd1};
    start_block(2'd0, 2'd0, 4'd8);
    apply_done(3'b111, 3'b000, 4'd5, 4'd3, 4'd4);
    collect(-1, 0, n, dc, un);
    vectors++;
    if ({sel_o, sel_len_o} !== {2'd1, 4'd3} || n != 3) begin
      errors++; $display("FAIL start_done: got sel %0d len %0d words %0d expected sel 1 len 3 words 3", sel_o, sel_len_o, n);
    end
    start_block(2'd2, 2'd0, 4'd8);
    apply_done(3'b111, 3'b000, 4'd2, 4'd2, 4'd2);
    collect(-1, 0, n, dc, un);
    vectors++;
    if ({sel_o, sel_len_o} !== {2'd3, 4'd8} || n != 0 || dc != 2) begin
      errors++;
      $display("FAIL bypass: got sel %0d len %0d words %0d done@%0d expected sel 3 len 8 words 0 done@2",
               sel_o, sel_len_o, n, dc);
    end
  endtask

  initial begin
    test_reset();
    test_auto();
    test_raw();
    test_forced();
    test_timeout();
    test_backpressure();
    test_robustness();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/aidc_lite_comp_arb.md
# aidc_lite_comp_arb

Parametrised result arbiter for the AIDC-Lite compression datapath. It generalises the fixed three-engine selection to NUM_COMP engines with configurable data width and buffer depth. It collects done/fail/length from every compressor and applies a selection mode (auto-smallest, forced engine, or raw bypass) with a timeout. It then streams the winning engine's buffer contents out over a valid/ready interface, and sits between the compressor buffers and the AHB write-back engine.

## Interface
- NUM_COMP, 3: number of compressor engines (1..8).
- DATA_W, 64: buffer word width.
- ADDR_W, 3: buffer address width; buffer depth is 2^ADDR_W words.
- TIMEOUT, 255: cycles allowed in WAIT before pending engines are treated as failed (1..65535).
- LEN_W = ADDR_W+1 and SEL_W = $clog2(NUM_COMP+1) are derived localparams.
---
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle start of a block; ignored unless in IDLE.
- mode_i  in  2  sampled at start: 0 = auto, 1 = forced, 2 = bypass, 3 = treated as bypass.
- force_sel_i  in  SEL_W  engine index used in forced mode; sampled at start.
- raw_len_i  in  LEN_W  uncompressed block length in words; sampled at start.
- done_i  in  NUM_COMP  per-engine done level/pulse.
- fail_i  in  NUM_COMP  per-engine fail; qualified by done_i.
- len_i  in  NUM_COMP*LEN_W  per-engine compressed length in words; engine k uses slice [k*LEN_W +: LEN_W], qualified by done_i.
- buf_raddr_o  out  ADDR_W  read address, shared by all engine buffers.
- rdata_i  in  NUM_COMP*DATA_W  per-engine buffer read data; valid one cycle after the address.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  output word accepted when high with out_valid_o.
- out_data_o  out  DATA_W  output word.
- out_last_o  out  1  final word of the selected block.
- sel_o  out  SEL_W  chosen engine; value NUM_COMP means raw (no compression). Stable from PICK until the next start.
- sel_len_o  out  LEN_W  length of the chosen stream; raw_len_i when raw.
- timeout_o  out  1  sticky per block: the WAIT phase expired.
- done_o  out  1  one-cycle pulse at block completion.

## Operation
- FSM states: IDLE, WAIT, PICK, RADDR, RDATA, OUT, FIN.
- IDLE: start_i latches mode, force_sel, and raw_len. It clears the done/fail/len latches, the timer, and timeout_o, then moves to WAIT.
- WAIT, done/fail latching:
  - From the cycle after start, done_i[k] sets the sticky bit done_q[k] and captures fail_q[k] and len_q[k].
  - Once done_q[k] is set, it ignores later done_i[k].
- WAIT, exit conditions:
  - Leaves to PICK when all done_q bits are set.
  - Also leaves to PICK when the timer reaches TIMEOUT-1. In that case timeout_o=1, and every engine not yet done is treated as fail.
  - If all engines are done on the same cycle the timer expires, the move to PICK happens with timeout_o=0.
- PICK (one cycle): engine k is a candidate when done_q&&!fail_q, len_q≥1, and len_q<raw_len.
  - Auto mode: the candidate with the smallest len_q wins; on equal length the lowest index wins. With no candidate the result is raw.
  - Forced mode: force_sel is used if it is a candidate; otherwise the result is raw. A force_sel ≥ NUM_COMP also gives raw.
  - Bypass mode: always raw.
- Raw result: PICK→FIN, and no words are streamed.
- Compressed result, streaming one word per iteration with idx counting 0..sel_len-1:
  - RADDR drives buf_raddr_o=idx.
  - RDATA registers the selected engine's rdata_i slice into out_data_o and sets out_valid_o.
  - OUT holds the word until out_ready_i. On acceptance it clears out_valid_o. If idx=sel_len-1 it goes to FIN; otherwise it increments idx and returns to RADDR.
- out_last_o is high with out_valid_o when idx=sel_len-1.
- FIN: done_o=1 for one cycle, then IDLE.
- In any state other than IDLE, start_i is ignored.
- Arithmetic: the timer is 16-bit and saturating. idx is ADDR_W bits and never wraps, because sel_len ≤ 2^ADDR_W.

## Timing
- Reset values: state IDLE, and every output is 0: buf_raddr_o, out_valid_o, out_data_o, out_last_o, sel_o, sel_len_o, timeout_o, done_o.
- Reset mid-operation aborts the block: the FSM returns to IDLE and no done_o is produced.
- Latency from start_i to PICK: the latest done_i cycle plus 1.
- PICK→FIN is 1 cycle for raw; done_o follows one cycle after FIN is entered.
- Per-word cost is 3 cycles minimum (RADDR, RDATA, OUT with out_ready_i=1). First out_valid_o comes 3 cycles after PICK.
- Output rules: out_data_o and out_last_o stay stable while out_valid_o=1 and out_ready_i=0. out_valid_o never drops without acceptance.
- A done_i arriving on the start_i cycle itself is not latched.

## Test plan
- Auto pick: NUM_COMP=3, raw_len=8, done with lens {5,3,3}, no fails → sel_o=1, sel_len_o=3. Three words come from engine 1's buffer at addresses 0,1,2; out_last_o is on the third; then a done_o pulse.
- All engines fail, or every len ≥ raw_len (e.g. lens {8,9,8}, raw_len=8) → sel_o=3 (raw), no out_valid_o, done_o 2 cycles after PICK.
- Forced mode, force_sel=2: engine 2 succeeds with len 6 → sel_o=2 even though engine 0 has len 2. Repeat with engine 2 failing → raw.
- Timeout: TIMEOUT=20, engines 0 and 1 done with lens 4 and 2, engine 2 never done → timeout_o=1 after 20 WAIT cycles, sel_o=1.
- Backpressure: hold out_ready_i low for 5 cycles on word 1 → data and last stay stable, no address advance, exactly sel_len words delivered.
- Robustness: assert rst mid-stream after word 0 → all outputs return to 0 next cycle. A start_i pulsed during WAIT is ignored, and a fresh start afterwards completes normally.
